lfsr_prng_stream: RTL and testbench

//  Parametrised Fibonacci LFSR pseudo-random word source for the FV encryption datapath.

---
 rtl/lfsr_prng_stream.sv | 82 ++++++++
 tb/tb_lfsr_prng_stream.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_prng_stream.sv
// Fibonacci LFSR word source: OUT_W fresh LFSR bits per word, delivered on a valid/ready stream.
// Define LFSR_PRNG_LOCKUP_EN to reject zero seeds and recover from an all-zero state.
module lfsr_prng_stream #(
    parameter int               WIDTH = 64,
    parameter logic [WIDTH-1:0] TAPS  = 64'hD800_0000_0000_0000,
    parameter logic [WIDTH-1:0] SEED  = 64'hFEDC_BA98_7654_3210,
    parameter int               OUT_W = 64
) (
    input  logic             clk,
    input  logic             s_rst,
    input  logic             en,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             lockup_err
);

    logic [WIDTH-1:0] st;
    logic [WIDTH-1:0] st_adv;
    logic             take;
    logic             gen;
    logic             seed_zero;
    logic             state_zero;

    // OUT_W single steps unrolled into one combinational advance.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] s);
        logic [WIDTH-1:0] t;
        t = s;
        for (int i = 0; i < OUT_W; i++) begin
            t = {t[WIDTH-2:0], ^(t & TAPS)};
        end
        return t;
    endfunction

    assign st_adv = advance(st);

    // Stream handshake: a word transfers on every rising edge where out_valid && out_ready;
    // while out_valid && !out_ready, out_data and the LFSR state do not change.
    assign take = out_valid && out_ready;
    assign gen  = en && (!out_valid || out_ready);

`ifdef LFSR_PRNG_LOCKUP_EN
    assign seed_zero  = seed_load && (seed_in == '0);
    assign state_zero = (st == '0);

    always_ff @(posedge clk) begin
        if (s_rst) begin
            lockup_err <= 1'b0;
        end else begin
            lockup_err <= seed_zero || (!seed_load && gen && state_zero);
        end
    end
`else
    assign seed_zero  = 1'b0;
    assign state_zero = 1'b0;
    assign lockup_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (s_rst) begin
            st        <= SEED;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (seed_load) begin
            // Reseeding discards any pending word so consumers never see a stale-sequence value.
            st        <= seed_zero ? SEED : seed_in;
            out_valid <= 1'b0;
        end else if (gen && state_zero) begin
            st        <= SEED;
            out_valid <= 1'b0;
        end else if (gen) begin
            st        <= st_adv;
            out_data  <= st_adv[OUT_W-1:0];
            out_valid <= 1'b1;
        end else if (take) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lfsr_prng_stream.sv
// Directed bench for lfsr_prng_stream: three instances (8-bit/1-bit words, 8-bit/8-bit words, defaults).
module tb_lfsr_prng_stream;

    localparam logic [63:0] SEED64 = 64'hFEDC_BA98_7654_3210;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance a: WIDTH=8, OUT_W=1
    logic       rst_a = 1'b1, en_a = 1'b0, ld_a = 1'b0, rdy_a = 1'b0;
    logic [7:0] seed_a = 8'h00;
    logic       valid_a, lerr_a;
    logic [0:0] data_a;

    // Instance b: WIDTH=8, OUT_W=8
    logic       rst_b = 1'b1, en_b = 1'b0, ld_b = 1'b0, rdy_b = 1'b0;
    logic [7:0] seed_b = 8'h00;
    logic       valid_b, lerr_b;
    logic [7:0] data_b;

    // Instance c: default parameters
    logic        rst_c = 1'b1, en_c = 1'b0, ld_c = 1'b0, rdy_c = 1'b0;
    logic [63:0] seed_c = 64'h0;
    logic        valid_c, lerr_c;
    logic [63:0] data_c;

    lfsr_prng_stream #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01), .OUT_W(1)) dut_a (
        .clk(clk), .s_rst(rst_a), .en(en_a), .seed_load(ld_a), .seed_in(seed_a),
        .out_valid(valid_a), .out_ready(rdy_a), .out_data(data_a), .lockup_err(lerr_a)
    );

    lfsr_prng_stream #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01), .OUT_W(8)) dut_b (
        .clk(clk), .s_rst(rst_b), .en(en_b), .seed_load(ld_b), .seed_in(seed_b),
        .out_valid(valid_b), .out_ready(rdy_b), .out_data(data_b), .lockup_err(lerr_b)
    );

    lfsr_prng_stream dut_c (
        .clk(clk), .s_rst(rst_c), .en(en_c), .seed_load(ld_c), .seed_in(seed_c),
        .out_valid(valid_c), .out_ready(rdy_c), .out_data(data_c), .lockup_err(lerr_c)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [63:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference models written from the tap polynomials.
    function automatic logic [7:0] adv8(input logic [7:0] s);
        logic [7:0] t;
        t = s;
        for (int i = 0; i < 8; i++) t = {t[6:0], t[7] ^ t[5] ^ t[4] ^ t[3]};
        return t;
    endfunction

    function automatic logic [63:0] adv64(input logic [63:0] s);
        logic [63:0] t;
        t = s;
        for (int i = 0; i < 64; i++) t = {t[62:0], t[63] ^ t[62] ^ t[60] ^ t[59]};
        return t;
    endfunction

    logic [7:0]  st_tab [8];
    logic [63:0] m;
    logic [11:0] rdy_pat;
    int          cnt;
    int          n_acc;

    initial begin
        st_tab = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E, 8'h1C};

        // Reset
        tick;
        tick;
        check("rst_valid_a", valid_a, 0);
        check("rst_valid_b", valid_b, 0);
        check("rst_data_b",  data_b, 0);
        check("rst_st_b",    dut_b.st, 8'h01);
        check("rst_lerr_b",  lerr_b, 0);
        check("rst_valid_c", valid_c, 0);
        check("rst_st_c",    dut_c.st, SEED64);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

        // OUT_W=1: single-step state sequence and full period
        en_a = 1'b1; rdy_a = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick;
            check("a_state", dut_a.st, st_tab[i]);
            check("a_bit", data_a, st_tab[i][0]);
        end
        check("a_valid", valid_a, 1);
        cnt = 8;
        while (dut_a.st != 8'h01 && cnt < 300) begin
            tick;
            cnt++;
        end
        check("a_period", cnt, 255);
        en_a = 1'b0;

        // OUT_W=8: latency and first words
        en_b = 1'b1; rdy_b = 1'b1;
        tick;
        check("b_first_valid", valid_b, 1);
        check("b_first_word",  data_b, 8'h1C);
        tick;
        check("b_second_word", data_b, 8'h4B);
        tick;
        check("b_third_word",  data_b, adv8(8'h4B));
        en_b = 1'b0;
        tick;
        check("b_drain_valid", valid_b, 0);

        // Backpressure hold, then accept with no bubble
        rst_b = 1'b1; rdy_b = 1'b0;
        tick;
        rst_b = 1'b0;
        check("b_rerst_st", dut_b.st, 8'h01);
        en_b = 1'b1;
        tick;
        check("b_bp_first", data_b, 8'h1C);
        for (int i = 0; i < 5; i++) begin
            tick;
            check("b_bp_hold_data",  data_b, 8'h1C);
            check("b_bp_hold_valid", valid_b, 1);
        end
        rdy_b = 1'b1;
        tick;
        check("b_nobubble_valid", valid_b, 1);
        check("b_nobubble_data",  data_b, 8'h4B);

        // Reseed while a word is stalled
        rdy_b = 1'b0;
        tick;
        check("b_stall_data", data_b, 8'h4B);
        ld_b = 1'b1; seed_b = 8'h01;
        tick;
        ld_b = 1'b0;
        check("b_reseed_valid", valid_b, 0);
        check("b_reseed_st",    dut_b.st, 8'h01);
        tick;
        check("b_reseed_word_valid", valid_b, 1);
        check("b_reseed_word",       data_b, 8'h1C);

        // Zero seed
        en_b = 1'b0; rdy_b = 1'b1;
        tick;
        check("b_zero_pre_valid", valid_b, 0);
        ld_b = 1'b1; seed_b = 8'h00;
        tick;
        ld_b = 1'b0;
`ifdef LFSR_PRNG_LOCKUP_EN
        check("b_zero_st",   dut_b.st, 8'h01);
        check("b_zero_lerr", lerr_b, 1);
        tick;
        check("b_zero_lerr_pulse", lerr_b, 0);
        en_b = 1'b1;
        tick;
        check("b_zero_word_valid", valid_b, 1);
        check("b_zero_word",       data_b, 8'h1C);
`else
        check("b_zero_st",   dut_b.st, 8'h00);
        check("b_zero_lerr", lerr_b, 0);
        en_b = 1'b1;
        tick;
        check("b_zero_word_valid", valid_b, 1);
        check("b_zero_word",       data_b, 8'h00);
        tick;
        check("b_zero_word2", data_b, 8'h00);
        check("b_zero_lerr2", lerr_b, 0);
`endif
        en_b = 1'b0;

        // Default params: scoreboard against the 64-bit model with a ready pattern
        m = SEED64;
        for (int i = 0; i < 12; i++) begin
            m = adv64(m);
            exp_q.push_back(m);
        end
        rdy_pat = 12'b1011_0011_1101;
        n_acc = 0;
        en_c = 1'b1;
        for (int i = 0; i < 12; i++) begin
            rdy_c = rdy_pat[i];
            if (valid_c && rdy_c) begin
                if (exp_q.size() == 0) check("c_queue_empty", 1, 0);
                else check("c_word", data_c, exp_q.pop_front());
                n_acc++;
            end
            tick;
        end
        check("c_accepts", n_acc, 7);

        // Mid-stream reset restarts from SEED
        rst_c = 1'b1;
        tick;
        rst_c = 1'b0; rdy_c = 1'b1;
        check("c_rst_valid", valid_c, 0);
        check("c_rst_st",    dut_c.st, SEED64);
        check("c_rst_data",  data_c, 0);
        tick;
        check("c_restart_valid", valid_c, 1);
        check("c_restart_word",  data_c, adv64(SEED64));
        en_c = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
